// File: rtl/hazard_pkg.sv
// Shared types and default sizing for the pipeline hazard controller.
package hazard_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 64;
    localparam int TIMER_W     = 8;
endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with a clear that wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush control with a memory-wait watchdog and performance counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forwardingEn,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             src1Valid,
    input  logic             src2Valid,
    input  logic [3:0]       dst_EXE,
    input  logic [3:0]       dst_MEM,
    input  logic             wbEn_EXE,
    input  logic             wbEn_MEM,
    input  logic             memRead_EXE,
    input  logic             branchTaken,
    input  logic             memReq,
    input  logic             memReady,
    input  logic             clrCnt,
    output logic             freezePC,
    output logic             freezeIFID,
    output logic             flushIFID,
    output logic             flushIDEXE,
    output logic             freezeAll,
    output logic             memTimeout,
    output logic [CNT_W-1:0] hazardCnt,
    output logic [CNT_W-1:0] flushCnt,
    output logic [CNT_W-1:0] waitCnt
);
    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT - 1);

    state_e             state_q;
    logic [TIMER_W-1:0] timer_q;
    logic               memTimeout_q;

    logic matchExe, matchMem, hazard, memWait;

    assign matchExe = (src1Valid && (src1 == dst_EXE)) || (src2Valid && (src2 == dst_EXE));
    assign matchMem = (src1Valid && (src1 == dst_MEM)) || (src2Valid && (src2 == dst_MEM));

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign hazard = forwardingEn ? (memRead_EXE && wbEn_EXE && matchExe)
                                 : ((wbEn_EXE && matchExe) || (wbEn_MEM && matchMem));

    assign memWait    = memReq && !memReady;
    assign freezeAll  = (state_q == ERROR) ? 1'b1 : memWait;
    assign freezePC   = freezeAll || (hazard && !branchTaken);
    assign freezeIFID = freezePC;
    assign flushIFID  = branchTaken && !freezeAll;
    assign flushIDEXE = (branchTaken || hazard) && !freezeAll;
    assign memTimeout = memTimeout_q;

    // Timer holds the number of consecutive wait cycles already completed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            timer_q      <= '0;
            memTimeout_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (memWait) begin
                        state_q <= MEM_WAIT;
                        timer_q <= TIMER_W'(1);
                    end else begin
                        timer_q <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (memReady) begin
                        state_q <= RUN;
                        timer_q <= '0;
                    end else if (timer_q == TMO_LAST) begin
                        state_q      <= ERROR;
                        memTimeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                ERROR: begin
                    memTimeout_q <= 1'b1;
                end
                default: begin
                    state_q <= RUN;
                    timer_q <= '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_hazard_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (hazard && !branchTaken && !freezeAll),
        .clr   (clrCnt),
        .count (hazardCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (branchTaken && !freezeAll),
        .clr   (clrCnt),
        .count (flushCnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (freezeAll),
        .clr   (clrCnt),
        .count (waitCnt)
    );
endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed scenarios followed by random traffic.
module tb_hazard_controller;
    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 4;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic forwardingEn = 0, src1Valid = 0, src2Valid = 0;
    logic [3:0] src1 = 0, src2 = 0, dst_EXE = 0, dst_MEM = 0;
    logic wbEn_EXE = 0, wbEn_MEM = 0, memRead_EXE = 0, branchTaken = 0;
    logic memReq = 0, memReady = 0, clrCnt = 0;
    logic freezePC, freezeIFID, flushIFID, flushIDEXE, freezeAll, memTimeout;
    logic [CNT_W-1:0] hazardCnt, flushCnt, waitCnt;

    hazard_controller #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .forwardingEn(forwardingEn),
        .src1(src1), .src2(src2), .src1Valid(src1Valid), .src2Valid(src2Valid),
        .dst_EXE(dst_EXE), .dst_MEM(dst_MEM), .wbEn_EXE(wbEn_EXE), .wbEn_MEM(wbEn_MEM),
        .memRead_EXE(memRead_EXE), .branchTaken(branchTaken),
        .memReq(memReq), .memReady(memReady), .clrCnt(clrCnt),
        .freezePC(freezePC), .freezeIFID(freezeIFID), .flushIFID(flushIFID),
        .flushIDEXE(flushIDEXE), .freezeAll(freezeAll), .memTimeout(memTimeout),
        .hazardCnt(hazardCnt), .flushCnt(flushCnt), .waitCnt(waitCnt)
    );

    typedef struct packed {
        logic rst, fwd, v1, v2;
        logic [3:0] s1, s2, dE, dM;
        logic wbE, wbM, mrE, br, mreq, mrdy, clr;
    } stim_t;

    typedef struct packed {
        logic fPC, fIFID, flIFID, flIDEXE, fAll, tmo;
        logic [CNT_W-1:0] hz, fl, wt;
    } exp_t;

    exp_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: error flag, length of the current wait episode, counter values.
    bit m_err, m_episode;
    int m_streak, m_hz, m_fl, m_wt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic bit reads(stim_t s, logic [3:0] d);
        return (s.v1 && s.s1 == d) || (s.v2 && s.s2 == d);
    endfunction

    task automatic model_reset();
        m_err = 0; m_episode = 0; m_streak = 0; m_hz = 0; m_fl = 0; m_wt = 0;
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        bit hz, mwait, fall;
        @(posedge clk);
        #1;
        rst = s.rst; forwardingEn = s.fwd; src1Valid = s.v1; src2Valid = s.v2;
        src1 = s.s1; src2 = s.s2; dst_EXE = s.dE; dst_MEM = s.dM;
        wbEn_EXE = s.wbE; wbEn_MEM = s.wbM; memRead_EXE = s.mrE; branchTaken = s.br;
        memReq = s.mreq; memReady = s.mrdy; clrCnt = s.clr;
        if (!s.rst) model_reset();
        hz = s.fwd ? (s.mrE && s.wbE && reads(s, s.dE))
                   : ((s.wbE && reads(s, s.dE)) || (s.wbM && reads(s, s.dM)));
        mwait = s.mreq && !s.mrdy;
        fall  = m_err ? 1'b1 : mwait;
        e.fPC = fall || (hz && !s.br);
        e.fIFID = e.fPC;
        e.flIFID = s.br && !fall;
        e.flIDEXE = (s.br || hz) && !fall;
        e.fAll = fall;
        e.tmo = m_err;
        e.hz = CNT_W'(m_hz); e.fl = CNT_W'(m_fl); e.wt = CNT_W'(m_wt);
        exp_q.push_back(e);
        if (s.rst) begin
            if (s.clr) begin
                m_hz = 0; m_fl = 0; m_wt = 0;
            end else begin
                if (hz && !s.br && !fall && m_hz < MAXC) m_hz++;
                if (s.br && !fall && m_fl < MAXC) m_fl++;
                if (fall && m_wt < MAXC) m_wt++;
            end
            if (!m_err) begin
                if (!m_episode) begin
                    if (mwait) begin m_episode = 1; m_streak = 1; end
                end else if (s.mrdy) begin
                    m_episode = 0; m_streak = 0;
                end else begin
                    m_streak++;
                    if (m_streak >= TIMEOUT) begin m_err = 1; m_episode = 0; end
                end
            end
        end
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ctrl", {26'd0, freezePC, freezeIFID, flushIFID, flushIDEXE, freezeAll, memTimeout},
                  {26'd0, e.fPC, e.fIFID, e.flIFID, e.flIDEXE, e.fAll, e.tmo});
            check("counters", 32'({hazardCnt, flushCnt, waitCnt}), 32'({e.hz, e.fl, e.wt}));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s, lu;
        int cnt;
        model_reset();

        s = idle(); s.rst = 0;
        step(s); step(s);
        check("reset_tmo", 32'(memTimeout), 0);
        check("reset_cnt", 32'({hazardCnt, flushCnt, waitCnt}), 0);
        step(idle());

        lu = idle(); lu.fwd = 1; lu.mrE = 1; lu.wbE = 1; lu.dE = 3; lu.s1 = 3; lu.v1 = 1;
        step(lu);
        check("loaduse_stall", 32'({freezePC, freezeIFID, flushIDEXE, flushIFID}), 32'b1110);
        step(idle());
        check("loaduse_cnt", 32'(hazardCnt), 1);

        s = idle(); s.wbM = 1; s.dM = 5; s.s2 = 5; s.v2 = 1; s.dE = 7; s.wbE = 1;
        step(s);
        check("nofwd_mem_stall", 32'(freezePC), 1);
        s.fwd = 1;
        step(s);
        check("fwd_mem_nostall", 32'(freezePC), 0);

        s = lu; s.br = 1;
        step(s);
        check("br_hz_flush", 32'({flushIFID, flushIDEXE, freezePC}), 32'b110);
        step(idle());
        check("br_hz_flushcnt", 32'(flushCnt), 1);
        check("br_hz_hazcnt", 32'(hazardCnt), 2);

        s = idle(); s.clr = 1; step(s);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.mreq = 1; s.br = 1;
            step(s);
            cnt += int'(freezeAll);
            check("wait_noflush", 32'({flushIFID, flushIDEXE}), 0);
        end
        s = idle(); s.mreq = 1; s.mrdy = 1; step(s); cnt += int'(freezeAll);
        step(idle()); cnt += int'(freezeAll);
        check("wait_freeze_cycles", 32'(cnt), 3);
        check("wait_cnt", 32'(waitCnt), 3);

        for (int i = 0; i < TIMEOUT; i++) begin
            s = idle(); s.mreq = 1; step(s);
        end
        check("tmo_not_yet", 32'(memTimeout), 0);
        step(idle());
        check("tmo_flag", 32'({memTimeout, freezeAll}), 32'b11);
        s = idle(); s.rst = 0; step(s);
        check("tmo_reset", 32'({memTimeout, freezeAll, waitCnt}), 0);
        step(idle());

        s = idle(); s.clr = 1; step(s);
        for (int i = 0; i < 5; i++) step(lu);
        step(idle());
        check("sat_hazcnt", 32'(hazardCnt), MAXC);
        s = lu; s.clr = 1; step(s);
        step(idle());
        check("clr_wins", 32'(hazardCnt), 0);

        for (int i = 0; i < 600; i++) begin
            s.rst  = ($urandom_range(0, m_err ? 4 : 49) != 0);
            s.fwd  = 1'($urandom);
            s.v1   = 1'($urandom);
            s.v2   = 1'($urandom);
            s.s1   = 4'($urandom_range(0, 3));
            s.s2   = 4'($urandom_range(0, 3));
            s.dE   = 4'($urandom_range(0, 3));
            s.dM   = 4'($urandom_range(0, 3));
            s.wbE  = 1'($urandom);
            s.wbM  = 1'($urandom);
            s.mrE  = 1'($urandom);
            s.br   = ($urandom_range(0, 3) == 0);
            s.mreq = ($urandom_range(0, 3) == 0) || (m_episode && $urandom_range(0, 1) == 0);
            s.mrdy = ($urandom_range(0, 2) == 0);
            s.clr  = ($urandom_range(0, 15) == 0);
            step(s);
        end

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
